// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main control FSM. Datapath controls are decoded from the current
// state, plus mem_ready in FETCH. The opcode is captured in DECODE for use by MEMADR.
module main_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_J_EX     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;

  assign state = r_state;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode latch, loaded only while decoding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode <= 6'b000000;
    end else if (r_state == S_DECODE) begin
      r_opcode <= opcode;
    end else begin
      r_opcode <= r_opcode;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next      = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPE_EX;
          OP_BEQ:       w_next = S_BEQ_EX;
          OP_J:         w_next = S_J_EX;
          OP_ADDI:      w_next = S_ADDI_EX;
          default: begin
            w_next     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Decided by the latched opcode; the IR input may already have moved on
        case (r_opcode)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BEQ_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_J_EX: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Table-driven bench for main_control_fsm: per-cycle vectors of inputs and expected
// state/controls, plus hand-written asynchronous reset sequences in stalled memory states.
module tb_main_control_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;

  main_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  PCSource[1:0],ALUOp[1:0],ALUSrcB[1:0],illegal_op}
  logic [16:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal_op};

  localparam logic [16:0] C_FETCH_RDY = 17'b1_0_0_1_0_0_1_0_0_0_00_00_01_0;
  localparam logic [16:0] C_FETCH_STL = 17'b0_0_0_1_0_0_0_0_0_0_00_00_01_0;
  localparam logic [16:0] C_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_11_0;
  localparam logic [16:0] C_DECODE_IL = 17'b0_0_0_0_0_0_0_0_0_0_00_00_11_1;
  localparam logic [16:0] C_MEMADR    = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_MEMRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB     = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_RTYPE_EX  = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_RTYPE_WB  = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [16:0] C_BEQ_EX    = 17'b0_1_0_0_0_0_0_1_0_0_01_01_00_0;
  localparam logic [16:0] C_J_EX      = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [16:0] C_ADDI_EX   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [16:0] c);
    vec_t v;
    v.rst_n = r; v.op = o; v.mr = m; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp_st, input logic [16:0] exp_ctl);
    n_vec++;
    if (state !== exp_st || ctl !== exp_ctl) begin
      n_err++;
      $display("FAIL %s: state=%0d ctl=%b, required state=%0d ctl=%b",
               name, state, ctl, exp_st, exp_ctl);
    end
    if ((MemRead && MemWrite) || (RegWrite && PCWrite)) begin
      n_err++;
      $display("FAIL %s exclusivity: MemRead=%b MemWrite=%b RegWrite=%b PCWrite=%b, required no overlap",
               name, MemRead, MemWrite, RegWrite, PCWrite);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] s, input logic [16:0] c);
    @(negedge clk);
    reset_n = r; opcode = o; mem_ready = m;
    #1;
    check(name, s, c);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b0;

    // reset and fetch stall
    add(1'b0, 6'b000000, 1'b1, 4'd0, C_FETCH_RDY);
    add(1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_STL);
    add(1'b1, 6'b000000, 1'b0, 4'd0, C_FETCH_STL);
    add(1'b1, 6'b000000, 1'b1, 4'd0, C_FETCH_RDY);
    // lw, live opcode changes after DECODE, read stalls one cycle
    add(1'b1, 6'b100011, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b000000, 1'b1, 4'd2, C_MEMADR);
    add(1'b1, 6'b000000, 1'b0, 4'd3, C_MEMRD);
    add(1'b1, 6'b000000, 1'b1, 4'd3, C_MEMRD);
    add(1'b1, 6'b000000, 1'b1, 4'd4, C_MEMWB);
    add(1'b1, 6'b000000, 1'b1, 4'd0, C_FETCH_RDY);
    // R-type
    add(1'b1, 6'b000000, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b000000, 1'b1, 4'd6, C_RTYPE_EX);
    add(1'b1, 6'b000000, 1'b1, 4'd7, C_RTYPE_WB);
    add(1'b1, 6'b000000, 1'b1, 4'd0, C_FETCH_RDY);
    // sw, live opcode flips to lw in MEMADR, write stalls 3 cycles
    add(1'b1, 6'b101011, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b100011, 1'b0, 4'd2, C_MEMADR);
    add(1'b1, 6'b100011, 1'b0, 4'd5, C_MEMWR);
    add(1'b1, 6'b100011, 1'b0, 4'd5, C_MEMWR);
    add(1'b1, 6'b100011, 1'b0, 4'd5, C_MEMWR);
    add(1'b1, 6'b100011, 1'b1, 4'd5, C_MEMWR);
    add(1'b1, 6'b000100, 1'b1, 4'd0, C_FETCH_RDY);
    // beq then j
    add(1'b1, 6'b000100, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b000100, 1'b1, 4'd8, C_BEQ_EX);
    add(1'b1, 6'b000010, 1'b1, 4'd0, C_FETCH_RDY);
    add(1'b1, 6'b000010, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b000010, 1'b1, 4'd9, C_J_EX);
    add(1'b1, 6'b001000, 1'b1, 4'd0, C_FETCH_RDY);
    // addi
    add(1'b1, 6'b001000, 1'b1, 4'd1, C_DECODE);
    add(1'b1, 6'b001000, 1'b1, 4'd10, C_ADDI_EX);
    add(1'b1, 6'b001000, 1'b1, 4'd11, C_ADDI_WB);
    add(1'b1, 6'b111111, 1'b1, 4'd0, C_FETCH_RDY);
    // illegal opcode
    add(1'b1, 6'b111111, 1'b1, 4'd1, C_DECODE_IL);
    add(1'b1, 6'b000000, 1'b1, 4'd0, C_FETCH_RDY);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].ctl);
    end

    // Asynchronous reset while MEMRD is stalled
    step("a_rst",   1'b0, 6'b100011, 1'b1, 4'd0, C_FETCH_RDY);
    step("a_rel",   1'b1, 6'b100011, 1'b1, 4'd0, C_FETCH_RDY);
    step("a_dec",   1'b1, 6'b100011, 1'b1, 4'd1, C_DECODE);
    step("a_adr",   1'b1, 6'b000000, 1'b0, 4'd2, C_MEMADR);
    step("a_rd",    1'b1, 6'b000000, 1'b0, 4'd3, C_MEMRD);
    #2 reset_n = 1'b0;
    #1 check("a_async", 4'd0, C_FETCH_STL);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("a_held", 4'd0, C_FETCH_RDY);
    reset_n = 1'b1;
    step("a_after", 1'b1, 6'b000000, 1'b1, 4'd1, C_DECODE);

    // Asynchronous reset while MEMWR is stalled
    step("b_rst",   1'b0, 6'b101011, 1'b1, 4'd0, C_FETCH_RDY);
    step("b_rel",   1'b1, 6'b101011, 1'b1, 4'd0, C_FETCH_RDY);
    step("b_dec",   1'b1, 6'b101011, 1'b1, 4'd1, C_DECODE);
    step("b_adr",   1'b1, 6'b101011, 1'b0, 4'd2, C_MEMADR);
    step("b_wr",    1'b1, 6'b101011, 1'b0, 4'd5, C_MEMWR);
    #2 reset_n = 1'b0;
    #1 check("b_async", 4'd0, C_FETCH_STL);
    step("b_hold",  1'b1, 6'b101011, 1'b0, 4'd0, C_FETCH_STL);
    step("b_stall", 1'b1, 6'b101011, 1'b0, 4'd0, C_FETCH_STL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameters: none; encodings below are fixed.
REQ-002 clk  input  1  single clock; state register updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; forces state FETCH immediately.
REQ-004 opcode  input  6  instr[31:26] from the instruction register; sampled in DECODE only.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 ALUOp  output  2  00 add, 01 subtract, 10 use funct; drives the ALU control unit.
REQ-009 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 state  output  4  current state code (debug/verification).
REQ-011 illegal_op  output  1  high for the DECODE cycle with an unsupported opcode.

Function
REQ-012 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, J_EX 9, ADDI_EX 10, ADDI_WB 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; any other is illegal.
REQ-014 Outputs are decoded from state (plus mem_ready where stated); every output not listed for a state SHALL be 0.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, else -> DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: lw/sw -> MEMADR, R -> RTYPE_EX, beq -> BEQ_EX, j -> J_EX, addi -> ADDI_EX, illegal -> FETCH with illegal_op=1.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD if latched opcode is lw, MEMWR if sw.
REQ-018 MEMRD: MemRead=1, IorD=1; holds while mem_ready=0; -> MEMWB on mem_ready=1.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; holds while mem_ready=0; -> FETCH on mem_ready=1.
REQ-021 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RTYPE_WB. RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-022 BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-023 J_EX: PCWrite=1, PCSource=10; -> FETCH.
REQ-024 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDI_WB. ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-025 opcode SHALL be latched into an internal 6-bit register on the DECODE cycle; MEMADR uses the latched copy, not the live input.
REQ-026 Cycle counts with mem_ready held 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and PCWrite SHALL never be 1 in the same cycle.

Reset
REQ-028 While reset_n=0: state=FETCH, latched opcode=000000, illegal_op=0; outputs equal FETCH decode with mem_ready gating (IRWrite/PCWrite follow mem_ready).
REQ-029 Reset assertion in any state, including a stalled MEMRD/MEMWR, SHALL abandon the instruction; first edge after release evaluates FETCH.

Verification
REQ-030 mem_ready=1, opcode 100011 -> state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-031 opcode 000000 -> states 0,1,6,7,0; ALUOp=10 in state 6, RegDst=1/RegWrite=1 in state 7.
REQ-032 opcode 101011, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, state 5 held until mem_ready=1, then 0.
REQ-033 opcode 000100 then 000010 -> states 0,1,8,0,1,9,0; PCWriteCond=1/ALUOp=01 in 8, PCWrite=1/PCSource=10 in 9.
REQ-034 opcode 111111 -> illegal_op=1 for one cycle in state 1, next state 0, no RegWrite/MemWrite/PCWrite pulse.
REQ-035 reset_n pulled low mid-MEMRD (state 3) -> state 0 asynchronously, MemRead=1, IorD=0 before next clock edge.
